// File: rtl/fifo_serial_tx_pkg.sv
// fifo_serial_tx_pkg
// Shared definitions for the FIFO-fed serial transmitter: default
// parameter values and the 3-bit FSM state encodings.
// Ports: none (package).
package fifo_serial_tx_pkg;

   localparam int CLKS_PER_BIT_DEF = 16;
   localparam int PARITY_EN_DEF    = 0;

   localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
   localparam logic [2:0] ST_FETCH_ENC  = 3'd1;
   localparam logic [2:0] ST_LATCH_ENC  = 3'd2;
   localparam logic [2:0] ST_START_ENC  = 3'd3;
   localparam logic [2:0] ST_DATA_ENC   = 3'd4;
   localparam logic [2:0] ST_PARITY_ENC = 3'd5;
   localparam logic [2:0] ST_STOP_ENC   = 3'd6;

   typedef enum logic [2:0] {
      ST_IDLE   = ST_IDLE_ENC,
      ST_FETCH  = ST_FETCH_ENC,
      ST_LATCH  = ST_LATCH_ENC,
      ST_START  = ST_START_ENC,
      ST_DATA   = ST_DATA_ENC,
      ST_PARITY = ST_PARITY_ENC,
      ST_STOP   = ST_STOP_ENC
   } tx_state_e;

endpackage

// File: rtl/fifo_serial_tx_baud_cnt.sv
// tx_baud_cnt
// Bit-period counter for the serial transmitter. Counts 0..CLKS_PER_BIT-1
// and wraps; clear forces the next count to 0 so every state starts on a
// fresh bit period.
// Ports:
//   clk   - clock
//   rst   - asynchronous active-high reset
//   clear - restart the bit period on the next edge
//   tick  - high on the last cycle of the current bit period
module tx_baud_cnt
   import fifo_serial_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

   logic [15:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clear || (cnt_q == LAST)) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx
// Pulls bytes from a FIFO and sends them as 8N1 (or 8E1) serial frames.
// Ports:
//   clk        - clock
//   rst        - asynchronous active-high reset
//   buf_cnt    - FIFO word count, nonzero = byte available
//   fifo_data  - FIFO read data, valid the cycle after the read strobe
//   fifo_rd_en - single-cycle FIFO read strobe
//   tx         - registered serial line, idle high
//   busy       - FSM not idle
//   frame_done - pulse on the last cycle of the stop bit
//   tx_count   - completed frame count, wraps
//
// state  | meaning
// IDLE   | line high, waiting for buf_cnt != 0
// FETCH  | one-cycle FIFO read strobe
// LATCH  | wait for read data, capture it on exit
// START  | start bit (low)
// DATA   | 8 data bits, LSB first
// PARITY | even parity bit (only when PARITY_EN)
// STOP   | stop bit (high), frame_done on its last cycle
module fifo_serial_tx
   import fifo_serial_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int PARITY_EN    = PARITY_EN_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  buf_cnt,
   input  logic [7:0]  fifo_data,
   output logic        fifo_rd_en,
   output logic        tx,
   output logic        busy,
   output logic        frame_done,
   output logic [15:0] tx_count
);

   tx_state_e   state_q, state_d;
   logic [7:0]  shreg_q, shreg_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic        par_q, par_d;
   logic        tx_q, tx_d;
   logic [15:0] tx_count_q;
   logic        tick;
   logic        clear;

   tx_baud_cnt #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .tick  (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         shreg_q   <= '0;
         bit_idx_q <= '0;
         par_q     <= 1'b0;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_idx_q <= bit_idx_d;
         par_q     <= par_d;
         tx_q      <= tx_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_count_q <= '0;
      end else if (frame_done) begin
         tx_count_q <= tx_count_q + 16'd1;
      end
   end

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_idx_d = bit_idx_q;
      par_d     = par_q;
      case (state_q)
         ST_IDLE: begin
            if (buf_cnt != 8'd0) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            state_d = ST_LATCH;
         end
         ST_LATCH: begin
            shreg_d   = fifo_data;
            par_d     = ^fifo_data;
            bit_idx_d = 3'd0;
            state_d   = ST_START;
         end
         ST_START: begin
            if (tick) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (tick) begin
               // index wraps back to 0 after bit 7
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
               end else begin
                  shreg_d = {1'b0, shreg_q[7:1]};
               end
            end
         end
         ST_PARITY: begin
            if (tick) state_d = ST_STOP;
         end
         ST_STOP: begin
            if (tick) state_d = (buf_cnt != 8'd0) ? ST_FETCH : ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Line level for the coming cycle, derived from the next-state values
   // so tx stays a pure register output.
   always_comb begin
      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shreg_d[0];
         ST_PARITY: tx_d = par_d;
         default:   tx_d = 1'b1;
      endcase
   end

   assign clear      = (state_d != state_q);
   assign fifo_rd_en = (state_q == ST_FETCH);
   assign busy       = (state_q != ST_IDLE);
   assign frame_done = (state_q == ST_STOP) && tick;
   assign tx         = tx_q;
   assign tx_count   = tx_count_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
module tb_fifo_serial_tx;

   localparam int CPB = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  buf_cnt = 8'd0, fifo_data = 8'd0;
   logic [7:0]  buf_cnt_p = 8'd0, fifo_data_p = 8'd0;
   logic        fifo_rd_en, tx, busy, frame_done;
   logic        fifo_rd_en_p, tx_p, busy_p, frame_done_p;
   logic [15:0] tx_count, tx_count_p;

   always #5 clk = ~clk;

   fifo_serial_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut (
      .clk(clk), .rst(rst), .buf_cnt(buf_cnt), .fifo_data(fifo_data),
      .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy),
      .frame_done(frame_done), .tx_count(tx_count)
   );

   fifo_serial_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut_p (
      .clk(clk), .rst(rst), .buf_cnt(buf_cnt_p), .fifo_data(fifo_data_p),
      .fifo_rd_en(fifo_rd_en_p), .tx(tx_p), .busy(busy_p),
      .frame_done(frame_done_p), .tx_count(tx_count_p)
   );

   logic [7:0] q0[$], q1[$], exp0[$], exp1[$];
   bit tx_log [2][65536];
   bit rd_log [2][65536];
   bit fd_log [2][65536];
   int cyc = 1;
   int n_cmp = 0, n_bad = 0;
   int cnt0 = 0, cnt1 = 0;
   bit rd_seen0 = 1'b0, rd_seen1 = 1'b0;

   // per-cycle trace, sampled mid-cycle
   always @(negedge clk) begin
      tx_log[0][cyc] = tx;         tx_log[1][cyc] = tx_p;
      rd_log[0][cyc] = fifo_rd_en; rd_log[1][cyc] = fifo_rd_en_p;
      fd_log[0][cyc] = frame_done; fd_log[1][cyc] = frame_done_p;
      rd_seen0 = fifo_rd_en;
      rd_seen1 = fifo_rd_en_p;
      if (cyc < 65535) cyc++;
   end

   // FIFO models: data appears shortly after the edge that took the strobe
   always @(posedge clk) begin
      #1;
      if (rd_seen0 && q0.size() > 0) fifo_data = q0.pop_front();
      if (rd_seen1 && q1.size() > 0) fifo_data_p = q1.pop_front();
      buf_cnt   = (q0.size() > 255) ? 8'd255 : 8'(q0.size());
      buf_cnt_p = (q1.size() > 255) ? 8'd255 : 8'(q1.size());
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push(input int d, input logic [7:0] b);
      if (d == 0) begin
         q0.push_back(b); exp0.push_back(b); cnt0 = (cnt0 + 1) % 65536;
      end else begin
         q1.push_back(b); exp1.push_back(b); cnt1 = (cnt1 + 1) % 65536;
      end
   endtask

   task automatic wait_idle(input int budget);
      bit ok = 1'b0;
      repeat (4) @(negedge clk);
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (!busy && !busy_p && q0.size() == 0 && q1.size() == 0 &&
             buf_cnt == 8'd0 && buf_cnt_p == 8'd0) begin
            ok = 1'b1;
            break;
         end
      end
      chk("idle_reached", 32'(ok), 32'd1);
      repeat (2) @(negedge clk);
   endtask

   // Decode every frame in the trace window and compare with the bytes
   // that were queued; returns frame count and span of the burst.
   task automatic scan(input int d, input int par, input int t0, input int t1,
                       output int nfr, output int span);
      int i = t0;
      int len = (10 + par) * CPB;
      int first = -1, last_end = -1;
      int nrd = 0, nfd = 0;
      nfr = 0;
      for (int k = t0; k <= t1; k++) begin
         nrd += int'(rd_log[d][k]);
         nfd += int'(fd_log[d][k]);
      end
      while (i <= t1) begin
         if (tx_log[d][i-1] && !tx_log[d][i]) begin
            logic [7:0] e, val;
            bit lv [11];
            int bad = 0;
            if (i + len - 1 > t1) begin
               chk("frame_truncated", 32'd1, 32'd0);
               break;
            end
            for (int b = 0; b < 10 + par; b++) begin
               lv[b] = tx_log[d][i + b*CPB];
               for (int k = 0; k < CPB; k++)
                  if (tx_log[d][i + b*CPB + k] != lv[b]) bad++;
            end
            for (int b = 0; b < 8; b++) val[b] = lv[b+1];
            if (d == 0) begin
               if (exp0.size() == 0) begin chk("extra_frame", 32'd1, 32'd0); break; end
               e = exp0.pop_front();
            end else begin
               if (exp1.size() == 0) begin chk("extra_frame", 32'd1, 32'd0); break; end
               e = exp1.pop_front();
            end
            chk("bit_hold", 32'(bad), 32'd0);
            chk("start_bit", 32'(lv[0]), 32'd0);
            chk("data_byte", 32'(val), 32'(e));
            if (par != 0) chk("parity_bit", 32'(lv[9]), 32'(^e));
            chk("stop_bit", 32'(lv[9+par]), 32'd1);
            chk("rd_two_before_start", 32'(rd_log[d][i-2]), 32'd1);
            chk("done_on_last_stop", 32'(fd_log[d][i+len-1]), 32'd1);
            if (first < 0) first = i;
            last_end = i + len;
            nfr++;
            i += len;
         end else begin
            i++;
         end
      end
      chk("rd_pulses", 32'(nrd), 32'(nfr));
      chk("done_pulses", 32'(nfd), 32'(nfr));
      chk("frames_missing", 32'(d == 0 ? exp0.size() : exp1.size()), 32'd0);
      span = (first < 0) ? 0 : last_end - first;
   endtask

   initial begin
      int t0, nfr, span, n, nrd, nlow;
      bit seen;

      repeat (3) @(negedge clk);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_tx_count", 32'(tx_count), 32'd0);
      chk("rst_tx_p", 32'(tx_p), 32'd1);
      rst = 1'b0;

      // idle with empty FIFO
      t0 = cyc;
      repeat (100) @(negedge clk);
      nrd = 0; nlow = 0;
      for (int k = t0; k < cyc; k++) begin
         nrd  += int'(rd_log[0][k]) + int'(rd_log[1][k]);
         nlow += int'(!tx_log[0][k]) + int'(!tx_log[1][k]);
      end
      chk("idle_rd_pulses", 32'(nrd), 32'd0);
      chk("idle_tx_low", 32'(nlow), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);

      // single byte
      t0 = cyc;
      push(0, 8'hA5);
      wait_idle(500);
      scan(0, 0, t0, cyc - 1, nfr, span);
      chk("single_frames", 32'(nfr), 32'd1);
      chk("single_len", 32'(span), 32'(10*CPB));
      chk("single_count", 32'(tx_count), 32'(cnt0));

      // back-to-back burst
      t0 = cyc;
      push(0, 8'h00); push(0, 8'hFF); push(0, 8'h55);
      wait_idle(1000);
      scan(0, 0, t0, cyc - 1, nfr, span);
      chk("b2b_frames", 32'(nfr), 32'd3);
      chk("b2b_span", 32'(span), 32'(3*10*CPB + 4));
      chk("b2b_count", 32'(tx_count), 32'(cnt0));

      // parity frame
      t0 = cyc;
      push(1, 8'h07);
      wait_idle(500);
      scan(1, 1, t0, cyc - 1, nfr, span);
      chk("par_frames", 32'(nfr), 32'd1);
      chk("par_len", 32'(span), 32'(11*CPB));
      chk("par_count", 32'(tx_count_p), 32'(cnt1));

      // random bursts into both instances
      for (int r = 0; r < 8; r++) begin
         t0 = cyc;
         n = int'($urandom_range(1, 4));
         for (int k = 0; k < n; k++) begin
            push(0, 8'($urandom));
            push(1, 8'($urandom));
         end
         wait_idle(3000);
         scan(0, 0, t0, cyc - 1, nfr, span);
         chk("rnd_frames", 32'(nfr), 32'(n));
         chk("rnd_span", 32'(span), 32'(n*10*CPB + (n-1)*2));
         scan(1, 1, t0, cyc - 1, nfr, span);
         chk("rnd_frames_p", 32'(nfr), 32'(n));
         chk("rnd_span_p", 32'(span), 32'(n*11*CPB + (n-1)*2));
         chk("rnd_count", 32'(tx_count), 32'(cnt0));
         chk("rnd_count_p", 32'(tx_count_p), 32'(cnt1));
         repeat (int'($urandom_range(0, 7))) @(negedge clk);
      end

      // reset during data bit 3 of 0x3C
      t0 = cyc;
      push(0, 8'h3C);
      seen = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (fifo_rd_en) begin seen = 1'b1; break; end
      end
      chk("abort_rd_seen", 32'(seen), 32'd1);
      repeat (19) @(negedge clk);
      chk("abort_in_frame", 32'(busy), 32'd1);
      chk("abort_bit3_level", 32'(tx), 32'd1);
      rst = 1'b1;
      #1;
      chk("abort_tx", 32'(tx), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_frame_done", 32'(frame_done), 32'd0);
      chk("abort_count", 32'(tx_count), 32'd0);
      void'(exp0.pop_back());
      cnt0 = 0; cnt1 = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (100) @(negedge clk);
      nrd = 0;
      for (int k = t0; k < cyc; k++) nrd += int'(fd_log[0][k]);
      chk("abort_no_done", 32'(nrd), 32'd0);
      chk("abort_count_after", 32'(tx_count), 32'd0);
      chk("abort_idle_after", 32'(busy), 32'd0);

      // counter wrap
      force dut.tx_count_q = 16'hFFFF;
      @(negedge clk);
      release dut.tx_count_q;
      @(negedge clk);
      chk("wrap_preload", 32'(tx_count), 32'h0000FFFF);
      t0 = cyc;
      push(0, 8'($urandom));
      wait_idle(500);
      scan(0, 0, t0, cyc - 1, nfr, span);
      chk("wrap_count", 32'(tx_count), 32'h00000000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
